// File: rtl/ising_run_ctrl.sv
// Run sequencer for the coupled-oscillator Ising array: spin programming hold,
// free run with periodic phase sampling, and stop on convergence or budget.
module ising_run_ctrl #(
  parameter int unsigned N           = 8,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             axi_rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] init_cycles,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic [CNT_W-1:0] sample_period,
  input  logic [CNT_W-1:0] stable_target,
  input  logic [N-1:0]     spin_init,
  input  logic [N-1:0]     spin_phase,
  output logic             ising_rstn,
  output logic [N-1:0]     spin_drive,
  output logic             busy,
  output logic             done,
  output logic             converged,
  output logic             aborted,
  output logic [N-1:0]     spins_out,
  output logic [CNT_W-1:0] cycles_out
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] init_cfg_q, init_cfg_d, run_cfg_q, run_cfg_d;
  logic [CNT_W-1:0] per_cfg_q, per_cfg_d, tgt_cfg_q, tgt_cfg_d;
  logic [N-1:0]     spin_cfg_q, spin_cfg_d;
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d, run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] samp_cnt_q, samp_cnt_d, stable_q, stable_d;
  logic             base_q, base_d;
  logic             ising_rstn_q, ising_rstn_d, busy_q, busy_d;
  logic             done_q, done_d, conv_q, conv_d, aborted_q, aborted_d;
  logic [N-1:0]     spin_drive_q, spin_drive_d, spins_q, spins_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [N-1:0]     sync_q [SYNC_STAGES];
  logic [N-1:0]     phase_c;
  logic             last_c, wrap_c, conv_c;

  function automatic logic [CNT_W-1:0] eff(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_ONE : v;
  endfunction

  // Metastability synchronizer on the free-running oscillator phases.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= spin_phase;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign phase_c = sync_q[SYNC_STAGES-1];
  assign last_c  = (run_cnt_q == eff(run_cfg_q));
  assign wrap_c  = (samp_cnt_q == eff(per_cfg_q));

  always_comb begin
    state_d      = state_q;
    init_cfg_d   = init_cfg_q;
    run_cfg_d    = run_cfg_q;
    per_cfg_d    = per_cfg_q;
    tgt_cfg_d    = tgt_cfg_q;
    spin_cfg_d   = spin_cfg_q;
    init_cnt_d   = init_cnt_q;
    run_cnt_d    = run_cnt_q;
    samp_cnt_d   = samp_cnt_q;
    stable_d     = stable_q;
    base_d       = base_q;
    conv_d       = conv_q;
    spins_d      = spins_q;
    cycles_d     = cycles_q;
    ising_rstn_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    spin_drive_d = '0;
    conv_c       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          init_cfg_d   = init_cycles;
          run_cfg_d    = run_cycles;
          per_cfg_d    = sample_period;
          tgt_cfg_d    = stable_target;
          spin_cfg_d   = spin_init;
          conv_d       = 1'b0;
          stable_d     = '0;
          base_d       = 1'b0;
          run_cnt_d    = '0;
          samp_cnt_d   = '0;
          init_cnt_d   = CNT_ONE;
          spin_drive_d = spin_init;
          busy_d       = 1'b1;
          state_d      = S_INIT;
        end
      end
      S_INIT: begin
        if (abort) begin
          aborted_d = 1'b1;
          cycles_d  = run_cnt_q;
          state_d   = S_IDLE;
        end else if (init_cnt_q == eff(init_cfg_q)) begin
          run_cnt_d    = CNT_ONE;
          samp_cnt_d   = CNT_ONE;
          ising_rstn_d = 1'b1;
          busy_d       = 1'b1;
          state_d      = S_RUN;
        end else begin
          init_cnt_d   = init_cnt_q + CNT_ONE;
          spin_drive_d = spin_cfg_q;
          busy_d       = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
          cycles_d  = run_cnt_q;
          state_d   = S_IDLE;
        end else begin
          samp_cnt_d = wrap_c ? CNT_ONE : samp_cnt_q + CNT_ONE;
          // The budget's final cycle always captures so spins_out reflects the end state.
          if (wrap_c || last_c) begin
            spins_d = phase_c;
            base_d  = 1'b1;
            if (base_q) begin
              if (phase_c == spins_q) begin
                stable_d = (stable_q == CNT_MAX) ? stable_q : stable_q + CNT_ONE;
              end else begin
                stable_d = '0;
              end
            end
            conv_c = (tgt_cfg_q != '0) && (stable_d == tgt_cfg_q);
          end
          if (conv_c || last_c) begin
            done_d   = 1'b1;
            conv_d   = conv_c;
            cycles_d = run_cnt_q;
            state_d  = S_DONE;
          end else begin
            run_cnt_d    = run_cnt_q + CNT_ONE;
            ising_rstn_d = 1'b1;
            busy_d       = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q      <= S_IDLE;
      init_cfg_q   <= '0;
      run_cfg_q    <= '0;
      per_cfg_q    <= '0;
      tgt_cfg_q    <= '0;
      spin_cfg_q   <= '0;
      init_cnt_q   <= '0;
      run_cnt_q    <= '0;
      samp_cnt_q   <= '0;
      stable_q     <= '0;
      base_q       <= 1'b0;
      conv_q       <= 1'b0;
      spins_q      <= '0;
      cycles_q     <= '0;
      ising_rstn_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      spin_drive_q <= '0;
    end else begin
      state_q      <= state_d;
      init_cfg_q   <= init_cfg_d;
      run_cfg_q    <= run_cfg_d;
      per_cfg_q    <= per_cfg_d;
      tgt_cfg_q    <= tgt_cfg_d;
      spin_cfg_q   <= spin_cfg_d;
      init_cnt_q   <= init_cnt_d;
      run_cnt_q    <= run_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      stable_q     <= stable_d;
      base_q       <= base_d;
      conv_q       <= conv_d;
      spins_q      <= spins_d;
      cycles_q     <= cycles_d;
      ising_rstn_q <= ising_rstn_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      spin_drive_q <= spin_drive_d;
    end
  end

  assign ising_rstn = ising_rstn_q;
  assign spin_drive = spin_drive_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign converged  = conv_q;
  assign aborted    = aborted_q;
  assign spins_out  = spins_q;
  assign cycles_out = cycles_q;

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Bench for ising_run_ctrl: scenario tasks drive runs and compare against a
// run-level model of the sequencing rules.
module tb_ising_run_ctrl;
  localparam int unsigned N  = 8;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          axi_rstn;
  logic          start, abort;
  logic [CW-1:0] init_cycles, run_cycles, sample_period, stable_target;
  logic [N-1:0]  spin_init, spin_phase;
  logic          ising_rstn, busy, done, converged, aborted;
  logic [N-1:0]  spin_drive, spins_out;
  logic [CW-1:0] cycles_out;

  ising_run_ctrl #(.N(N), .CNT_W(CW), .SYNC_STAGES(2)) dut (
    .clk(clk), .axi_rstn(axi_rstn), .start(start), .abort(abort),
    .init_cycles(init_cycles), .run_cycles(run_cycles),
    .sample_period(sample_period), .stable_target(stable_target),
    .spin_init(spin_init), .spin_phase(spin_phase),
    .ising_rstn(ising_rstn), .spin_drive(spin_drive), .busy(busy),
    .done(done), .converged(converged), .aborted(aborted),
    .spins_out(spins_out), .cycles_out(cycles_out)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0, n_pass = 0;
  logic [N-1:0] pv [0:2047];
  logic [N-1:0] hold_spins = '0;
  int unsigned  post_len = 3;
  int unsigned  ob_init, ob_busy, ob_run, ob_done, ob_ab, ob_cyc;
  bit           ob_fin, ob_conv, ob_ab_rstn;
  logic [N-1:0] ob_spins;
  int unsigned  e_len;
  bit           e_conv;
  logic [N-1:0] e_sp;

  // Phase schedules, indexed by cycles since the start request.
  task automatic fill_pv(input int mode);
    logic [N-1:0] v;
    v = N'($urandom);
    for (int k = 0; k < 2048; k++) begin
      if (mode == 1) pv[k] = 8'h3C;
      else if (mode == 2) pv[k] = 8'h3C ^ N'((k / 5) % 2);
      else begin
        if ($urandom_range(5, 0) == 0) v[$urandom_range(N-1, 0)] ^= 1'b1;
        pv[k] = v;
      end
    end
  endtask

  // Run-level model: the sample taken in RUN cycle c is the phase driven two
  // cycles earlier (two-flop synchronizer).
  function automatic void predict(input int unsigned i, r, p, t, ab,
                                  output int unsigned len, output bit conv,
                                  output logic [N-1:0] sp);
    int unsigned ie, re, pe, st;
    bit base;
    logic [N-1:0] v;
    ie = (i == 0) ? 1 : i;
    re = (r == 0) ? 1 : r;
    pe = (p == 0) ? 1 : p;
    st = 0; base = 0; sp = hold_spins; conv = 0; len = re;
    for (int unsigned c = 1; c <= re; c++) begin
      if (ab != 0 && c == ab) begin len = c; return; end
      if (c % pe == 0 || c == re) begin
        v = pv[ie + c - 2];
        if (!base) base = 1;
        else if (v == sp) st++;
        else st = 0;
        sp = v;
        if (t != 0 && st == t) begin conv = 1; len = c; return; end
      end
    end
  endfunction

  task automatic drive_run(input int unsigned i, r, p, t, input logic [N-1:0] si,
                           input int unsigned ab, ms);
    bit fin;
    int unsigned post;
    ob_init = 0; ob_busy = 0; ob_run = 0; ob_done = 0; ob_ab = 0; ob_cyc = 0;
    ob_fin = 0; ob_conv = 0; ob_ab_rstn = 0; ob_spins = '0;
    fin = 0; post = 0;
    init_cycles = CW'(i); run_cycles = CW'(r); sample_period = CW'(p);
    stable_target = CW'(t); spin_init = si; start = 1'b1; abort = 1'b0;
    spin_phase = pv[0];
    for (int k = 1; k < 2000; k++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      if (busy === 1'b1 && ising_rstn === 1'b0 && spin_drive === si) ob_init++;
      if (busy === 1'b1) ob_busy++;
      if (ising_rstn === 1'b1) ob_run++;
      if (done === 1'b1) begin
        ob_done++; ob_conv = converged; ob_spins = spins_out; ob_cyc = cycles_out; fin = 1;
      end
      if (aborted === 1'b1) begin
        ob_ab++; ob_spins = spins_out; ob_cyc = cycles_out; ob_ab_rstn = ising_rstn; fin = 1;
      end
      if (fin) begin
        if (post == post_len) break;
        post++;
      end
      spin_phase = pv[k];
      if (ising_rstn === 1'b1 && ab != 0 && ob_run == ab) abort = 1'b1;
      if (ising_rstn === 1'b1 && ms != 0 && ob_run == ms) begin
        start = 1'b1; run_cycles = CW'(5);
      end
    end
    ob_fin = fin;
  endtask

  task automatic test_reset();
    axi_rstn = 1'b0; start = 0; abort = 0; init_cycles = '0; run_cycles = '0;
    sample_period = '0; stable_target = '0; spin_init = '0; spin_phase = '0;
    repeat (2) @(negedge clk);
    n_chk++; if (ising_rstn !== 1'b0) $display("FAIL reset_rstn: got %b want 0", ising_rstn); else n_pass++;
    n_chk++; if ({busy, done, converged, aborted} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {busy, done, converged, aborted}); else n_pass++;
    n_chk++; if ({spin_drive, spins_out} !== 16'h0) $display("FAIL reset_spins: got %h want 0000", {spin_drive, spins_out}); else n_pass++;
    n_chk++; if (cycles_out !== '0) $display("FAIL reset_cycles: got %0d want 0", cycles_out); else n_pass++;
    axi_rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    fill_pv(0);
    predict(3, 10, 4, 0, 0, e_len, e_conv, e_sp);
    drive_run(3, 10, 4, 0, 8'hA5, 0, 0);
    hold_spins = e_sp;
    n_chk++; if (ob_fin !== 1'b1) $display("FAIL basic_fin: run did not finish"); else n_pass++;
    n_chk++; if (ob_init != 3) $display("FAIL basic_init: got %0d want 3", ob_init); else n_pass++;
    n_chk++; if (ob_run != 10) $display("FAIL basic_run: got %0d want 10", ob_run); else n_pass++;
    n_chk++; if (ob_busy != 13) $display("FAIL basic_busy: got %0d want 13", ob_busy); else n_pass++;
    n_chk++; if (ob_done != 1) $display("FAIL basic_done: got %0d want 1", ob_done); else n_pass++;
    n_chk++; if (ob_conv !== 1'b0) $display("FAIL basic_conv: got %b want 0", ob_conv); else n_pass++;
    n_chk++; if (ob_cyc != 10) $display("FAIL basic_cycles: got %0d want 10", ob_cyc); else n_pass++;
    n_chk++; if (ob_spins !== e_sp) $display("FAIL basic_spins: got %h want %h", ob_spins, e_sp); else n_pass++;
  endtask

  task automatic test_converge();
    fill_pv(1);
    drive_run(2, 100, 2, 3, 8'h5A, 0, 0);
    hold_spins = 8'h3C;
    n_chk++; if (ob_done != 1) $display("FAIL conv_done: got %0d want 1", ob_done); else n_pass++;
    n_chk++; if (ob_conv !== 1'b1) $display("FAIL conv_flag: got %b want 1", ob_conv); else n_pass++;
    n_chk++; if (ob_spins !== 8'h3C) $display("FAIL conv_spins: got %h want 3c", ob_spins); else n_pass++;
    n_chk++; if (ob_cyc != 8) $display("FAIL conv_cycles: got %0d want 8", ob_cyc); else n_pass++;
    n_chk++; if (converged !== 1'b1) $display("FAIL conv_hold: got %b want 1", converged); else n_pass++;
  endtask

  task automatic test_toggle();
    fill_pv(2);
    predict(2, 20, 2, 3, 0, e_len, e_conv, e_sp);
    drive_run(2, 20, 2, 3, 8'h0F, 0, 0);
    hold_spins = e_sp;
    n_chk++; if (ob_conv !== e_conv || e_conv !== 1'b0) $display("FAIL toggle_conv: got %b want 0", ob_conv); else n_pass++;
    n_chk++; if (ob_cyc != 20) $display("FAIL toggle_cycles: got %0d want 20", ob_cyc); else n_pass++;
    n_chk++; if (ob_spins !== e_sp) $display("FAIL toggle_spins: got %h want %h", ob_spins, e_sp); else n_pass++;
  endtask

  task automatic test_abort();
    fill_pv(0);
    predict(2, 30, 4, 0, 5, e_len, e_conv, e_sp);
    post_len = 0;
    drive_run(2, 30, 4, 0, 8'hC3, 5, 0);
    post_len = 3;
    hold_spins = e_sp;
    n_chk++; if (ob_ab != 1 || ob_done != 0) $display("FAIL abort_pulse: got ab=%0d done=%0d want 1 0", ob_ab, ob_done); else n_pass++;
    n_chk++; if (ob_ab_rstn !== 1'b0) $display("FAIL abort_rstn: got %b want 0", ob_ab_rstn); else n_pass++;
    n_chk++; if (ob_cyc != 5) $display("FAIL abort_cycles: got %0d want 5", ob_cyc); else n_pass++;
    n_chk++; if (ob_spins !== e_sp) $display("FAIL abort_spins: got %h want %h", ob_spins, e_sp); else n_pass++;
    predict(1, 6, 3, 0, 0, e_len, e_conv, e_sp);
    drive_run(1, 6, 3, 0, 8'h81, 0, 0);
    hold_spins = e_sp;
    n_chk++; if (ob_done != 1 || ob_cyc != 6) $display("FAIL abort_restart: got done=%0d cyc=%0d want 1 6", ob_done, ob_cyc); else n_pass++;
  endtask

  task automatic test_mid_start();
    fill_pv(0);
    predict(2, 12, 3, 0, 0, e_len, e_conv, e_sp);
    drive_run(2, 12, 3, 0, 8'h77, 0, 4);
    hold_spins = e_sp;
    n_chk++; if (ob_run != 12 || ob_cyc != 12) $display("FAIL midstart_budget: got run=%0d cyc=%0d want 12", ob_run, ob_cyc); else n_pass++;
    n_chk++; if (ob_done != 1 || ob_busy != 14) $display("FAIL midstart_once: got done=%0d busy=%0d want 1 14", ob_done, ob_busy); else n_pass++;
  endtask

  task automatic test_random();
    int unsigned i, r, p, t;
    logic [N-1:0] si;
    for (int n = 0; n < 8; n++) begin
      fill_pv(0);
      i = $urandom_range(4, 0); r = $urandom_range(40, 0);
      p = $urandom_range(5, 0); t = $urandom_range(4, 0); si = N'($urandom);
      predict(i, r, p, t, 0, e_len, e_conv, e_sp);
      drive_run(i, r, p, t, si, 0, 0);
      hold_spins = e_sp;
      n_chk++;
      if (ob_run != e_len || ob_cyc != e_len || ob_conv !== e_conv || ob_spins !== e_sp ||
          ob_init != ((i == 0) ? 1 : i) || ob_done != 1)
        $display("FAIL rand_%0d: got run=%0d cyc=%0d conv=%b sp=%h init=%0d done=%0d want run=%0d conv=%b sp=%h",
                 n, ob_run, ob_cyc, ob_conv, ob_spins, ob_init, ob_done, e_len, e_conv, e_sp);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    fill_pv(0);
    init_cycles = CW'(2); run_cycles = CW'(50); sample_period = CW'(4);
    stable_target = '0; spin_init = 8'h99; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    n_chk++; if (ising_rstn !== 1'b1) $display("FAIL arst_pre: got %b want 1", ising_rstn); else n_pass++;
    #1 axi_rstn = 1'b0;
    #1;
    n_chk++; if (ising_rstn !== 1'b0 || busy !== 1'b0) $display("FAIL arst_now: got rstn=%b busy=%b want 0 0", ising_rstn, busy); else n_pass++;
    n_chk++; if ({done, converged, aborted, spin_drive, spins_out, cycles_out} !== '0) $display("FAIL arst_outs: got nonzero outputs"); else n_pass++;
    @(negedge clk); axi_rstn = 1'b1;
    hold_spins = '0;
    predict(0, 0, 0, 0, 0, e_len, e_conv, e_sp);
    drive_run(0, 0, 0, 0, 8'h42, 0, 0);
    hold_spins = e_sp;
    n_chk++; if (ob_init != 1 || ob_run != 1 || ob_cyc != 1) $display("FAIL arst_zero_cfg: got init=%0d run=%0d cyc=%0d want 1 1 1", ob_init, ob_run, ob_cyc); else n_pass++;
    n_chk++; if (ob_spins !== e_sp || ob_done != 1) $display("FAIL arst_zero_spins: got %h done=%0d want %h 1", ob_spins, ob_done, e_sp); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_converge();
    test_toggle();
    test_abort();
    test_mid_start();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
